vga_frame_monitor: RTL and testbench

//  Sink-side VGA monitor: samples VGA RGB/sync/blank driven by the display generator, measures active

---
 rtl/vga_frame_monitor.sv | 258 +++++++++++++++++++++++++
 tb/tb_vga_frame_monitor.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_monitor.sv
// Sink-side VGA monitor: measures active geometry and the foreground bounding box of each
// frame and publishes the committed results on a byte-wide Avalon-MM read port.
module vga_frame_monitor #(
  parameter logic [23:0] FG_COLOR = 24'hFFFFFF,
  parameter logic [10:0] EXP_W    = 11'd640,
  parameter logic [9:0]  EXP_H    = 10'd480
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] VGA_R,
  input  logic [7:0] VGA_G,
  input  logic [7:0] VGA_B,
  input  logic       VGA_CLK,
  input  logic       VGA_HS,
  input  logic       VGA_VS,
  input  logic       VGA_BLANK_n,
  input  logic       chipselect,
  input  logic       read,
  input  logic [3:0] address,
  output logic [7:0] readdata,
  output logic       dbg_state
);

  typedef enum logic {S_WAIT_SYNC = 1'b0, S_MEASURE = 1'b1} state_t;

  localparam logic [10:0] X_MAX = 11'd2047;
  localparam logic [9:0]  Y_MAX = 10'd1023;

  state_t state_q, state_d;

  // Input stage
  logic [23:0] rgb_q, rgb_d;
  logic        vclk_q, vclk_d, vclk_prev_q, vclk_prev_d;
  logic        hs_q, hs_d, hs_prev_q, hs_prev_d;
  logic        vs_q, vs_d, vs_prev_q, vs_prev_d;
  logic        blank_n_q, blank_n_d;

  // Working (in-progress frame) registers
  logic [10:0] x_cnt_q, x_cnt_d, line_w_q, line_w_d;
  logic [9:0]  y_cnt_q, y_cnt_d;
  logic        line_act_q, line_act_d;
  logic [10:0] wxmin_q, wxmin_d, wxmax_q, wxmax_d;
  logic [9:0]  wymin_q, wymin_d, wymax_q, wymax_d;
  logic        wfound_q, wfound_d;

  // Shadow (committed) registers
  logic [10:0] act_w_q, act_w_d;
  logic [9:0]  act_h_q, act_h_d;
  logic [10:0] sxmin_q, sxmin_d, sxmax_q, sxmax_d;
  logic [9:0]  symin_q, symin_d, symax_q, symax_d;
  logic        sfound_q, sfound_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic        frame_valid_q, frame_valid_d;
  logic        timing_err_q, timing_err_d;
  logic [7:0]  readdata_q, readdata_d;

  logic pix_ev, hs_fall, vs_fall;
  logic measure, commit, err_set, rd_en;

  assign pix_ev  = vclk_q & ~vclk_prev_q;
  assign hs_fall = hs_prev_q & ~hs_q;
  assign vs_fall = vs_prev_q & ~vs_q;
  assign rd_en   = chipselect & read;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_WAIT_SYNC;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT_SYNC: if (vs_fall) state_d = S_MEASURE;
      S_MEASURE:   state_d = S_MEASURE;
      default:     state_d = S_WAIT_SYNC;
    endcase
  end

  // FSM: outputs
  always_comb begin
    measure   = (state_q == S_MEASURE);
    commit    = measure & vs_fall;
    dbg_state = state_q;
  end

  always_comb begin
    rgb_d         = {VGA_R, VGA_G, VGA_B};
    vclk_d        = VGA_CLK;
    vclk_prev_d   = vclk_q;
    hs_d          = VGA_HS;
    hs_prev_d     = hs_q;
    vs_d          = VGA_VS;
    vs_prev_d     = vs_q;
    blank_n_d     = VGA_BLANK_n;

    x_cnt_d       = x_cnt_q;
    y_cnt_d       = y_cnt_q;
    line_w_d      = line_w_q;
    line_act_d    = line_act_q;
    wxmin_d       = wxmin_q;
    wxmax_d       = wxmax_q;
    wymin_d       = wymin_q;
    wymax_d       = wymax_q;
    wfound_d      = wfound_q;

    act_w_d       = act_w_q;
    act_h_d       = act_h_q;
    sxmin_d       = sxmin_q;
    sxmax_d       = sxmax_q;
    symin_d       = symin_q;
    symax_d       = symax_q;
    sfound_d      = sfound_q;
    frame_cnt_d   = frame_cnt_q;
    frame_valid_d = frame_valid_q;
    timing_err_d  = timing_err_q;
    readdata_d    = readdata_q;
    err_set       = 1'b0;

    // Active sample: bbox uses the pre-increment column of this pixel.
    if (measure && pix_ev && blank_n_q) begin
      if (rgb_q == FG_COLOR) begin
        if (x_cnt_q < wxmin_q) wxmin_d = x_cnt_q;
        if (x_cnt_q > wxmax_q) wxmax_d = x_cnt_q;
        if (y_cnt_q < wymin_q) wymin_d = y_cnt_q;
        if (y_cnt_q > wymax_q) wymax_d = y_cnt_q;
        wfound_d = 1'b1;
      end
      line_act_d = 1'b1;
      if (x_cnt_q != X_MAX) x_cnt_d = x_cnt_q + 11'd1;
    end

    // Line close precedes a same-cycle frame commit, so the commit sees the closed line.
    if (measure && hs_fall) begin
      if (line_act_d) begin
        if (y_cnt_q != Y_MAX) y_cnt_d = y_cnt_q + 10'd1;
        line_w_d = x_cnt_d;
      end
      x_cnt_d    = 11'd0;
      line_act_d = 1'b0;
    end

    if (commit) begin
      act_w_d       = line_w_d;
      act_h_d       = y_cnt_d;
      sxmin_d       = wxmin_d;
      sxmax_d       = wxmax_d;
      symin_d       = wymin_d;
      symax_d       = wymax_d;
      sfound_d      = wfound_d;
      frame_cnt_d   = frame_cnt_q + 8'd1;
      frame_valid_d = 1'b1;
      err_set       = (line_w_d != EXP_W) | (y_cnt_d != EXP_H);
    end

    if (vs_fall) begin
      x_cnt_d    = 11'd0;
      y_cnt_d    = 10'd0;
      line_w_d   = 11'd0;
      line_act_d = 1'b0;
      wxmin_d    = X_MAX;
      wxmax_d    = 11'd0;
      wymin_d    = Y_MAX;
      wymax_d    = 10'd0;
      wfound_d   = 1'b0;
    end

    // Status read clears the sticky error; a simultaneous new error wins.
    if (rd_en && address == 4'd13) timing_err_d = 1'b0;
    if (err_set) timing_err_d = 1'b1;

    if (rd_en) begin
      case (address)
        4'd0:    readdata_d = act_w_q[7:0];
        4'd1:    readdata_d = {5'b0, act_w_q[10:8]};
        4'd2:    readdata_d = act_h_q[7:0];
        4'd3:    readdata_d = {6'b0, act_h_q[9:8]};
        4'd4:    readdata_d = sxmin_q[7:0];
        4'd5:    readdata_d = {5'b0, sxmin_q[10:8]};
        4'd6:    readdata_d = sxmax_q[7:0];
        4'd7:    readdata_d = {5'b0, sxmax_q[10:8]};
        4'd8:    readdata_d = symin_q[7:0];
        4'd9:    readdata_d = {6'b0, symin_q[9:8]};
        4'd10:   readdata_d = symax_q[7:0];
        4'd11:   readdata_d = {6'b0, symax_q[9:8]};
        4'd12:   readdata_d = frame_cnt_q;
        4'd13:   readdata_d = {5'b0, timing_err_q, sfound_q, frame_valid_q};
        default: readdata_d = 8'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_q         <= 24'd0;
      vclk_q        <= 1'b0;
      vclk_prev_q   <= 1'b0;
      hs_q          <= 1'b1;
      hs_prev_q     <= 1'b1;
      vs_q          <= 1'b1;
      vs_prev_q     <= 1'b1;
      blank_n_q     <= 1'b0;
      x_cnt_q       <= 11'd0;
      y_cnt_q       <= 10'd0;
      line_w_q      <= 11'd0;
      line_act_q    <= 1'b0;
      wxmin_q       <= X_MAX;
      wxmax_q       <= 11'd0;
      wymin_q       <= Y_MAX;
      wymax_q       <= 10'd0;
      wfound_q      <= 1'b0;
      act_w_q       <= 11'd0;
      act_h_q       <= 10'd0;
      sxmin_q       <= X_MAX;
      sxmax_q       <= 11'd0;
      symin_q       <= Y_MAX;
      symax_q       <= 10'd0;
      sfound_q      <= 1'b0;
      frame_cnt_q   <= 8'd0;
      frame_valid_q <= 1'b0;
      timing_err_q  <= 1'b0;
      readdata_q    <= 8'd0;
    end else begin
      rgb_q         <= rgb_d;
      vclk_q        <= vclk_d;
      vclk_prev_q   <= vclk_prev_d;
      hs_q          <= hs_d;
      hs_prev_q     <= hs_prev_d;
      vs_q          <= vs_d;
      vs_prev_q     <= vs_prev_d;
      blank_n_q     <= blank_n_d;
      x_cnt_q       <= x_cnt_d;
      y_cnt_q       <= y_cnt_d;
      line_w_q      <= line_w_d;
      line_act_q    <= line_act_d;
      wxmin_q       <= wxmin_d;
      wxmax_q       <= wxmax_d;
      wymin_q       <= wymin_d;
      wymax_q       <= wymax_d;
      wfound_q      <= wfound_d;
      act_w_q       <= act_w_d;
      act_h_q       <= act_h_d;
      sxmin_q       <= sxmin_d;
      sxmax_q       <= sxmax_d;
      symin_q       <= symin_d;
      symax_q       <= symax_d;
      sfound_q      <= sfound_d;
      frame_cnt_q   <= frame_cnt_d;
      frame_valid_q <= frame_valid_d;
      timing_err_q  <= timing_err_d;
      readdata_q    <= readdata_d;
    end
  end

  assign readdata = readdata_q;

endmodule

// File: tb/tb_vga_frame_monitor.sv
// Bench for vga_frame_monitor: a small 8x4 raster generator drives the sink, register reads
// push expected bytes into a queue and a monitor pops them as readdata becomes valid.
module tb_vga_frame_monitor;
  localparam logic [23:0] FG = 24'hFFFFFF;
  localparam logic [23:0] BG = 24'h000080;
  localparam int W = 8;
  localparam int H = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] VGA_R, VGA_G, VGA_B;
  logic       VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_n;
  logic       chipselect, read;
  logic [3:0] address;
  logic [7:0] readdata;
  logic       dbg_state;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];
  string      nm_q[$];
  int         fgx_q[$];
  int         fgy_q[$];
  logic       rd_pend = 1'b0;

  vga_frame_monitor #(.FG_COLOR(FG), .EXP_W(11'(W)), .EXP_H(10'(H))) dut (
    .clk(clk), .reset(reset), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .VGA_CLK(VGA_CLK), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_n(VGA_BLANK_n),
    .chipselect(chipselect), .read(read), .address(address), .readdata(readdata),
    .dbg_state(dbg_state)
  );

  // Clock
  always #10 clk = ~clk;

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", nm, act, exp);
    end
  endtask

  // Monitor: readdata is valid on the negedge following a sampled read
  always @(posedge clk) rd_pend <= chipselect & read;
  always @(negedge clk) begin
    if (rd_pend) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_read: got 0x%02h expected none", readdata);
      end else begin
        check(nm_q.pop_front(), readdata, exp_q.pop_front());
      end
    end
  end

  function automatic bit is_fg(input int x, input int y);
    for (int i = 0; i < fgx_q.size(); i++)
      if (fgx_q[i] == x && fgy_q[i] == y) return 1'b1;
    return 1'b0;
  endfunction

  // Driver tasks
  task automatic pix(input logic bl, input logic hs, input logic vs, input logic [23:0] c);
    @(negedge clk);
    VGA_CLK = 1'b1; VGA_BLANK_n = bl; VGA_HS = hs; VGA_VS = vs;
    {VGA_R, VGA_G, VGA_B} = c;
    @(negedge clk);
    VGA_CLK = 1'b0;
  endtask

  task automatic line(input int w, input int y, input logic vs, input bit active);
    for (int x = 0; x < w; x++)
      pix(active, 1'b1, vs, (active && is_fg(x, y)) ? FG : BG);
    pix(1'b0, 1'b1, vs, 24'd0);
    pix(1'b0, 1'b0, vs, 24'd0);
    pix(1'b0, 1'b0, vs, 24'd0);
    pix(1'b0, 1'b1, vs, 24'd0);
  endtask

  // Active lines, front porch, vsync line (commit happens here), back porch
  task automatic frame(input int w);
    for (int y = 0; y < H; y++) line(w, y, 1'b1, 1'b1);
    line(w, 0, 1'b1, 1'b0);
    line(w, 0, 1'b0, 1'b0);
    line(w, 0, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
  endtask

  task automatic rd(input logic [3:0] a, input logic [7:0] exp, input string nm);
    @(negedge clk);
    chipselect = 1'b1; read = 1'b1; address = a;
    exp_q.push_back(exp);
    nm_q.push_back(nm);
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
  endtask

  task automatic rd_regs(input logic [10:0] w, input logic [9:0] h, input logic [10:0] x0,
                         input logic [10:0] x1, input logic [9:0] y0, input logic [9:0] y1,
                         input logic [7:0] fc, input logic [7:0] st);
    rd(4'd0,  w[7:0],                 "act_w_lo");
    rd(4'd1,  {5'b0, w[10:8]},        "act_w_hi");
    rd(4'd2,  h[7:0],                 "act_h_lo");
    rd(4'd3,  {6'b0, h[9:8]},         "act_h_hi");
    rd(4'd4,  x0[7:0],                "xmin_lo");
    rd(4'd5,  {5'b0, x0[10:8]},       "xmin_hi");
    rd(4'd6,  x1[7:0],                "xmax_lo");
    rd(4'd7,  {5'b0, x1[10:8]},       "xmax_hi");
    rd(4'd8,  y0[7:0],                "ymin_lo");
    rd(4'd9,  {6'b0, y0[9:8]},        "ymin_hi");
    rd(4'd10, y1[7:0],                "ymax_lo");
    rd(4'd11, {6'b0, y1[9:8]},        "ymax_hi");
    rd(4'd12, fc,                     "frame_cnt");
    rd(4'd13, st,                     "status");
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1'b1; VGA_CLK = 1'b0; VGA_HS = 1'b1; VGA_VS = 1'b1; VGA_BLANK_n = 1'b0;
    repeat (n) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic set_box(input int x0, input int x1, input int y0, input int y1);
    fgx_q.delete(); fgy_q.delete();
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++) begin
        fgx_q.push_back(x); fgy_q.push_back(y);
      end
  endtask

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected test end");
    $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; chipselect = 1'b0; read = 1'b0; address = 4'd0;
    VGA_R = 8'd0; VGA_G = 8'd0; VGA_B = 8'd0;
    VGA_CLK = 1'b0; VGA_HS = 1'b1; VGA_VS = 1'b1; VGA_BLANK_n = 1'b0;
    do_reset(3);
    @(negedge clk);
    check("readdata_reset", readdata, 8'h00);
    rd_regs(11'd0, 10'd0, 11'd2047, 11'd0, 10'd1023, 10'd0, 8'd0, 8'h00);
    rd(4'd14, 8'h00, "addr14");

    // No foreground: first frame discarded, second commits
    frame(W);
    frame(W);
    rd_regs(11'(W), 10'(H), 11'd2047, 11'd0, 10'd1023, 10'd0, 8'd1, 8'h01);

    // Foreground block
    set_box(2, 5, 1, 2);
    frame(W);
    rd_regs(11'(W), 10'(H), 11'd2, 11'd5, 10'd1, 10'd2, 8'd2, 8'h03);

    // Short lines: sticky timing error, cleared by status read
    frame(W - 1);
    rd_regs(11'(W - 1), 10'(H), 11'd2, 11'd5, 10'd1, 10'd2, 8'd3, 8'h07);
    rd(4'd13, 8'h03, "status_after_clear");
    rd(4'd15, 8'h00, "addr15");

    // Reset mid-line
    fgx_q.delete(); fgy_q.delete();
    for (int x = 0; x < 3; x++) pix(1'b1, 1'b1, 1'b1, BG);
    do_reset(3);
    @(negedge clk);
    check("readdata_midreset", readdata, 8'h00);
    rd_regs(11'd0, 10'd0, 11'd2047, 11'd0, 10'd1023, 10'd0, 8'd0, 8'h00);
    frame(W);
    frame(W);
    rd_regs(11'(W), 10'(H), 11'd2047, 11'd0, 10'd1023, 10'd0, 8'd1, 8'h01);

    // Corner pixels
    fgx_q.push_back(0);     fgy_q.push_back(0);
    fgx_q.push_back(W - 1); fgy_q.push_back(H - 1);
    frame(W);
    rd_regs(11'(W), 10'(H), 11'd0, 11'(W - 1), 10'd0, 10'(H - 1), 8'd2, 8'h03);

    // Frame counter wrap
    fgx_q.delete(); fgy_q.delete();
    do_reset(2);
    frame(W);
    for (int i = 0; i < 256; i++) frame(W);
    rd(4'd12, 8'd0, "frame_cnt_256");
    frame(W);
    rd(4'd12, 8'd1, "frame_cnt_257");
    rd(4'd0, 8'(W), "act_w_after_wrap");
    @(negedge clk);
    chipselect = 1'b0; read = 1'b1; address = 4'd12;
    @(negedge clk);
    read = 1'b0;
    @(negedge clk);
    check("no_cs_hold", readdata, 8'(W));

    repeat (4) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain: got %0d expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
